// File: rtl/nn_stream_tx.sv
// nn_stream_tx: host-side driver for the NN accelerator stream interface.
// The host preloads kernel and image words while the block is idle, then
// pulses start with an option code. The block sends Opt, then three kernel
// channels in parallel, then three image channels in parallel. It then
// waits for the NN result burst and stores it in a result buffer that the
// host reads through rd_addr/rd_data.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, opt_in          transfer request and option code (IDLE only)
//   wr_en, wr_addr, wr_data  input buffer write port (IDLE only)
//   rd_addr, rd_data       combinational result buffer read port
//   busy, done             status, done is a one-cycle end-of-transfer pulse
//   err_timeout, err_proto sticky error flags, cleared by an accepted start
//   in_valid_o/Opt, in_valid_k/Kernel1..3, in_valid_i/Image1..3  NN inputs
//   out_valid, out         NN result stream
module nn_stream_tx #(
   parameter int K_LEN   = 9,
   parameter int I_LEN   = 16,
   parameter int O_LEN   = 16,
   parameter int TIMEOUT = 1000,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    opt_in,
   input  logic          wr_en,
   input  logic [6:0]    wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [3:0]    rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          done,
   output logic          err_timeout,
   output logic          err_proto,
   output logic          in_valid_o,
   output logic [1:0]    Opt,
   output logic          in_valid_k,
   output logic [DW-1:0] Kernel1,
   output logic [DW-1:0] Kernel2,
   output logic [DW-1:0] Kernel3,
   output logic          in_valid_i,
   output logic [DW-1:0] Image1,
   output logic [DW-1:0] Image2,
   output logic [DW-1:0] Image3,
   input  logic          out_valid,
   input  logic [DW-1:0] out
);

   localparam int NWORDS = 3 * K_LEN + 3 * I_LEN;
   localparam int IBASE  = 3 * K_LEN;
   localparam int CW     = $clog2(TIMEOUT + 1);
   localparam int RW     = $clog2(O_LEN);

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] K_LAST   = CW'(K_LEN - 1);
   localparam logic [CW-1:0] I_LAST   = CW'(I_LEN - 1);
   localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] O_LAST   = CW'(O_LEN - 1);
   localparam logic [CW-1:0] O_FULL   = CW'(O_LEN);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEND_O = 3'd1,
      S_SEND_K = 3'd2,
      S_SEND_I = 3'd3,
      S_WAIT   = 3'd4,
      S_RECV   = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      opt_q, opt_d;
   logic            err_timeout_q, err_timeout_d;
   logic            err_proto_q, err_proto_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ivo_q, ivo_d;
   logic [1:0]      opt_o_q, opt_o_d;
   logic            ivk_q, ivk_d;
   logic            ivi_q, ivi_d;
   logic [DW-1:0]   k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
   logic [DW-1:0]   i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic            res_we;
   logic [RW-1:0]   res_idx;
   logic            buf_we;
   logic [6:0]      pidx;

   logic [DW-1:0]   ibuf_q [0:NWORDS-1];
   logic [DW-1:0]   res_q  [0:O_LEN-1];

   // State, counter and sticky-flag registers plus all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= CNT_ZERO;
         opt_q         <= 2'b00;
         err_timeout_q <= 1'b0;
         err_proto_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         ivo_q         <= 1'b0;
         opt_o_q       <= 2'b00;
         ivk_q         <= 1'b0;
         ivi_q         <= 1'b0;
         k1_q          <= {DW{1'b0}};
         k2_q          <= {DW{1'b0}};
         k3_q          <= {DW{1'b0}};
         i1_q          <= {DW{1'b0}};
         i2_q          <= {DW{1'b0}};
         i3_q          <= {DW{1'b0}};
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         opt_q         <= opt_d;
         err_timeout_q <= err_timeout_d;
         err_proto_q   <= err_proto_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         ivo_q         <= ivo_d;
         opt_o_q       <= opt_o_d;
         ivk_q         <= ivk_d;
         ivi_q         <= ivi_d;
         k1_q          <= k1_d;
         k2_q          <= k2_d;
         k3_q          <= k3_d;
         i1_q          <= i1_d;
         i2_q          <= i2_d;
         i3_q          <= i3_d;
      end
   end

   // Next-state logic: phase sequencing, counters, error detection
   // The one counter serves every phase. It counts words sent in SEND_K and
   // SEND_I, idle cycles in WAIT and words captured in RECV. A completed
   // burst leaves it at O_LEN, so FIN can tell a full burst from an aborted
   // one.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      opt_d         = opt_q;
      err_timeout_d = err_timeout_q;
      err_proto_d   = err_proto_q;
      res_we        = 1'b0;
      res_idx       = {RW{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_SEND_O;
               opt_d         = opt_in;
               err_timeout_d = 1'b0;
               err_proto_d   = 1'b0;
               cnt_d         = CNT_ZERO;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND_O: begin
            if (out_valid) begin
               err_proto_d = 1'b1;
               state_d     = S_FIN;
               cnt_d       = CNT_ZERO;
            end else begin
               state_d = S_SEND_K;
               cnt_d   = CNT_ZERO;
            end
         end
         S_SEND_K: begin
            if (out_valid) begin
               err_proto_d = 1'b1;
               state_d     = S_FIN;
               cnt_d       = CNT_ZERO;
            end else if (cnt_q == K_LAST) begin
               state_d = S_SEND_I;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_SEND_I: begin
            if (out_valid) begin
               err_proto_d = 1'b1;
               state_d     = S_FIN;
               cnt_d       = CNT_ZERO;
            end else if (cnt_q == I_LAST) begin
               state_d = S_WAIT;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_WAIT: begin
            if (out_valid) begin
               res_we  = 1'b1;
               res_idx = {RW{1'b0}};
               state_d = S_RECV;
               cnt_d   = CNT_ONE;
            end else if (cnt_q == T_LAST) begin
               // TIMEOUT idle cycles have elapsed, so abort.
               err_timeout_d = 1'b1;
               state_d       = S_FIN;
               cnt_d         = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RECV: begin
            if (out_valid) begin
               res_we  = 1'b1;
               res_idx = cnt_q[RW-1:0];
               if (cnt_q == O_LAST) begin
                  state_d = S_FIN;
                  cnt_d   = O_FULL;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               err_proto_d = 1'b1;
               state_d     = S_FIN;
               cnt_d       = CNT_ZERO;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            if (out_valid && (cnt_q == O_FULL)) begin
               err_proto_d = 1'b1;
            end else begin
               err_proto_d = err_proto_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output decode from the next state, so the NN-side outputs are registered
   // and line up with the state they describe.
   always_comb begin
      ivo_d   = 1'b0;
      opt_o_d = 2'b00;
      ivk_d   = 1'b0;
      ivi_d   = 1'b0;
      k1_d    = {DW{1'b0}};
      k2_d    = {DW{1'b0}};
      k3_d    = {DW{1'b0}};
      i1_d    = {DW{1'b0}};
      i2_d    = {DW{1'b0}};
      i3_d    = {DW{1'b0}};
      pidx    = 7'(cnt_d);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_FIN);
      case (state_d)
         S_SEND_O: begin
            ivo_d   = 1'b1;
            opt_o_d = opt_d;
         end
         S_SEND_K: begin
            ivk_d = 1'b1;
            k1_d  = ibuf_q[pidx];
            k2_d  = ibuf_q[pidx + 7'(K_LEN)];
            k3_d  = ibuf_q[pidx + 7'(2 * K_LEN)];
         end
         S_SEND_I: begin
            ivi_d = 1'b1;
            i1_d  = ibuf_q[pidx + 7'(IBASE)];
            i2_d  = ibuf_q[pidx + 7'(IBASE + I_LEN)];
            i3_d  = ibuf_q[pidx + 7'(IBASE + 2 * I_LEN)];
         end
         default: begin
            ivo_d = 1'b0;
         end
      endcase
   end

   assign buf_we = wr_en && (state_q == S_IDLE) && (wr_addr < 7'(NWORDS));

   // Host preload of the input buffer, accepted only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NWORDS; i++) ibuf_q[i] <= {DW{1'b0}};
      end else if (buf_we) begin
         ibuf_q[wr_addr] <= wr_data;
      end
   end

   // Result capture from the NN burst
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < O_LEN; i++) res_q[i] <= {DW{1'b0}};
      end else if (res_we) begin
         res_q[res_idx] <= out;
      end
   end

   assign rd_data     = res_q[rd_addr];
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_timeout_q;
   assign err_proto   = err_proto_q;
   assign in_valid_o  = ivo_q;
   assign Opt         = opt_o_q;
   assign in_valid_k  = ivk_q;
   assign Kernel1     = k1_q;
   assign Kernel2     = k2_q;
   assign Kernel3     = k3_q;
   assign in_valid_i  = ivi_q;
   assign Image1      = i1_q;
   assign Image2      = i2_q;
   assign Image3      = i3_q;

endmodule

// File: tb/tb_nn_stream_tx.sv
// Directed self-checking bench for nn_stream_tx. Word k of the input buffer
// holds 0x3F800000+k, so every expected kernel and image value follows
// directly from the word address.
module tb_nn_stream_tx;
   localparam int DW = 32;
   localparam logic [DW-1:0] WBASE = 32'h3F80_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    opt_in;
   logic          wr_en;
   logic [6:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    rd_addr;
   logic [DW-1:0] rd_data;
   logic          busy, done, err_timeout, err_proto;
   logic          in_valid_o, in_valid_k, in_valid_i;
   logic [1:0]    Opt;
   logic [DW-1:0] Kernel1, Kernel2, Kernel3, Image1, Image2, Image3;
   logic          out_valid;
   logic [DW-1:0] nn_out;

   int checks = 0;
   int errors = 0;
   int w;

   always #5 clk = ~clk;

   nn_stream_tx #(.K_LEN(9), .I_LEN(16), .O_LEN(16), .TIMEOUT(1000), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opt_in(opt_in),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .err_timeout(err_timeout), .err_proto(err_proto),
      .in_valid_o(in_valid_o), .Opt(Opt),
      .in_valid_k(in_valid_k), .Kernel1(Kernel1), .Kernel2(Kernel2), .Kernel3(Kernel3),
      .in_valid_i(in_valid_i), .Image1(Image1), .Image2(Image2), .Image3(Image3),
      .out_valid(out_valid), .out(nn_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Start a transfer and check the Opt, kernel and image phases cycle by
   // cycle. With poke set, a write to word 0 and a second start are issued
   // while images are streaming; both must be ignored.
   task automatic send(input logic [1:0] opt, input bit poke);
      start  = 1'b1;
      opt_in = opt;
      step();
      start = 1'b0;
      wr_en = 1'b0;
      chk1("opt_valid", in_valid_o, 1'b1);
      chk("opt_code", 32'(Opt), 32'(opt));
      chk1("busy_send", busy, 1'b1);
      chk1("k_valid_during_o", in_valid_k, 1'b0);
      for (int j = 0; j < 9; j++) begin
         step();
         chk1("k_valid", in_valid_k, 1'b1);
         chk1("o_valid_during_k", in_valid_o, 1'b0);
         chk1("i_valid_during_k", in_valid_i, 1'b0);
         chk("opt_zero_during_k", 32'(Opt), 32'd0);
         chk("kernel1", Kernel1, WBASE + 32'(j));
         chk("kernel2", Kernel2, WBASE + 32'(9 + j));
         chk("kernel3", Kernel3, WBASE + 32'(18 + j));
      end
      for (int j = 0; j < 16; j++) begin
         step();
         if (poke && j == 5) begin
            wr_en   = 1'b1;
            wr_addr = 7'd0;
            wr_data = 32'hDEAD_BEEF;
            start   = 1'b1;
            opt_in  = 2'b01;
         end else begin
            wr_en = 1'b0;
            start = 1'b0;
         end
         chk1("i_valid", in_valid_i, 1'b1);
         chk1("k_valid_during_i", in_valid_k, 1'b0);
         chk1("o_valid_during_i", in_valid_o, 1'b0);
         chk("kernel_zero_during_i", Kernel1, 32'd0);
         chk("image1", Image1, WBASE + 32'(27 + j));
         chk("image2", Image2, WBASE + 32'(43 + j));
         chk("image3", Image3, WBASE + 32'(59 + j));
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; opt_in = 2'b00; wr_en = 1'b0;
      wr_addr = 7'd0; wr_data = 32'd0; rd_addr = 4'd0;
      out_valid = 1'b0; nn_out = 32'd0;

      // ---- Reset then idle ----
      #12;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_done", done, 1'b0);
      chk1("idle_err_t", err_timeout, 1'b0);
      chk1("idle_err_p", err_proto, 1'b0);
      chk("idle_valids", {29'd0, in_valid_o, in_valid_k, in_valid_i}, 32'd0);
      chk("idle_opt", 32'(Opt), 32'd0);
      chk("idle_kernel", Kernel1 | Kernel2 | Kernel3, 32'd0);
      chk("idle_image", Image1 | Image2 | Image3, 32'd0);
      for (int n = 0; n < 16; n++) begin
         rd_addr = 4'(n);
         #1;
         chk("idle_rd_data", rd_data, 32'd0);
      end

      // ---- Full transfer; the last buffer write shares the start cycle ----
      step();
      for (int k = 0; k < 74; k++) begin
         wr_en   = 1'b1;
         wr_addr = 7'(k);
         wr_data = WBASE + 32'(k);
         step();
      end
      wr_addr = 7'd74;
      wr_data = WBASE + 32'd74;
      send(2'b10, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk1("wait_busy", busy, 1'b1);
         chk("wait_valids", {29'd0, in_valid_o, in_valid_k, in_valid_i}, 32'd0);
         chk1("wait_done", done, 1'b0);
      end
      step();
      for (int n = 0; n < 16; n++) begin
         out_valid = 1'b1;
         nn_out    = 32'h4000_0000 + 32'(n);
         chk1("recv_done_low", done, 1'b0);
         step();
      end
      out_valid = 1'b0;
      chk1("full_done", done, 1'b1);
      chk1("full_busy_fin", busy, 1'b1);
      chk1("full_err_t", err_timeout, 1'b0);
      chk1("full_err_p", err_proto, 1'b0);
      step();
      chk1("full_done_once", done, 1'b0);
      chk1("full_idle", busy, 1'b0);
      chk1("full_err_p_after", err_proto, 1'b0);
      for (int n = 0; n < 16; n++) begin
         rd_addr = 4'(n);
         #1;
         chk("full_result", rd_data, 32'h4000_0000 + 32'(n));
      end

      // ---- Timeout; kernel word 0 must still be the preloaded value ----
      step();
      send(2'b01, 1'b0);
      w = 0;
      while (done !== 1'b1 && w < 1100) begin
         step();
         w++;
      end
      chk1("timeout_done", done, 1'b1);
      chk("timeout_wait_cycles", 32'(w - 1), 32'd1000);
      chk1("timeout_err_t", err_timeout, 1'b1);
      chk1("timeout_err_p", err_proto, 1'b0);
      step();
      chk1("timeout_sticky", err_timeout, 1'b1);

      // ---- Short burst; new start clears err_timeout ----
      start  = 1'b1;
      opt_in = 2'b11;
      step();
      start = 1'b0;
      chk1("start_clears_err_t", err_timeout, 1'b0);
      // Run the remaining phases: 9 kernel and 16 image cycles.
      for (int j = 0; j < 25; j++) step();
      chk("short_last_image3", Image3, WBASE + 32'd74);
      step();
      for (int n = 0; n < 10; n++) begin
         out_valid = 1'b1;
         nn_out    = 32'h5000_0000 + 32'(n);
         step();
      end
      out_valid = 1'b0;
      step();
      chk1("short_done", done, 1'b1);
      chk1("short_err_p", err_proto, 1'b1);
      step();
      chk1("short_idle", busy, 1'b0);
      for (int n = 0; n < 16; n++) begin
         rd_addr = 4'(n);
         #1;
         if (n < 10) chk("short_new", rd_data, 32'h5000_0000 + 32'(n));
         else        chk("short_kept", rd_data, 32'h4000_0000 + 32'(n));
      end

      // ---- Early out_valid during the 4th kernel cycle ----
      step();
      start  = 1'b1;
      opt_in = 2'b00;
      step();
      start = 1'b0;
      chk1("early_err_p_cleared", err_proto, 1'b0);
      step(); step(); step(); step();
      chk("early_k4_kernel1", Kernel1, WBASE + 32'd3);
      out_valid = 1'b1;
      step();
      out_valid = 1'b0;
      chk("early_valids", {29'd0, in_valid_o, in_valid_k, in_valid_i}, 32'd0);
      chk("early_kernel", Kernel1 | Kernel2 | Kernel3, 32'd0);
      chk1("early_err_p", err_proto, 1'b1);
      chk1("early_done", done, 1'b1);
      step();
      chk1("early_done_once", done, 1'b0);
      chk1("early_idle", busy, 1'b0);

      // ---- Reset during RECV ----
      send(2'b10, 1'b0);
      step();
      for (int n = 0; n < 3; n++) begin
         out_valid = 1'b1;
         nn_out    = 32'h6000_0000 + 32'(n);
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      out_valid = 1'b0;
      rd_addr   = 4'd0;
      #1;
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_done", done, 1'b0);
      chk("arst_rd_data", rd_data, 32'd0);
      chk("arst_valids", {29'd0, in_valid_o, in_valid_k, in_valid_i}, 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("arst_no_done", done, 1'b0);
         chk1("arst_stay_idle", busy, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nn_stream_tx.md
Name: nn_stream_tx

Overview:
- Synthesizable host-side driver for the NN accelerator interface: the transmitting end of the Opt/Kernel/Image protocol and the receiving end of out_valid/out.
- The host preloads kernel and image words into an internal buffer, then pulses start with an option code.
- The block streams Opt, three kernel channels and three image channels to NN, then captures the NN result burst into a result buffer the host can read.
- It flags timeout and protocol violations.

Parameters:
- K_LEN, 9: kernel words per channel, sent on Kernel1..3 in parallel.
- I_LEN, 16: image words per channel, sent on Image1..3 in parallel.
- O_LEN, 16: result words expected in one out_valid burst.
- TIMEOUT, 1000: maximum idle cycles allowed from the last image cycle to the first out_valid.
- DW, 32: IEEE-754 single word width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- opt_in  in  2  option code latched on an accepted start.
- wr_en  in  1  buffer write strobe; honoured only in IDLE.
- wr_addr  in  7  word address: kernel c,i at c*K_LEN+i (0..26); image c,i at 27+c*I_LEN+i (27..74); addresses 75..127 ignored.
- wr_data  in  DW  word to write.
- rd_addr  in  4  result word index.
- rd_data  out  DW  result word, combinational read of the result buffer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer ends, whether successful or aborted.
- err_timeout  out  1  sticky; cleared by the next accepted start.
- err_proto  out  1  sticky; cleared by the next accepted start.
- in_valid_o  out  1  Opt valid.
- Opt  out  2  option code.
- in_valid_k  out  1  kernel valid.
- Kernel1, Kernel2, Kernel3  out  DW  kernel channels 0, 1, 2.
- in_valid_i  out  1  image valid.
- Image1, Image2, Image3  out  DW  image channels 0, 1, 2.
- out_valid  in  1  NN result valid.
- out  in  DW  NN result word.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Input buffer, result buffer, counters and sticky flags clear to 0.
  - Reset asserted mid-transfer aborts immediately, with no done pulse.
- All NN-side outputs are registered.
- Opt, Kernel* and Image* are 0 whenever their valid is low.
- FSM states: IDLE, SEND_O, SEND_K, SEND_I, WAIT, RECV, FIN.
- IDLE:
  - wr_en writes the buffer.
  - start latches opt_in, clears the error flags, and goes to SEND_O.
  - A write and a start in the same cycle: the write commits and is used by that transfer.
- Timing for start sampled at edge T:
  - in_valid_o=1 and Opt=opt for the cycle T+1..T+2.
  - SEND_K: in_valid_k=1 for K_LEN consecutive cycles; cycle j drives words j, 9+j, 18+j.
  - SEND_I: in_valid_i=1 for I_LEN consecutive cycles; cycle j drives words 27+j, 43+j, 59+j.
  - No gaps between phases; the valids are mutually exclusive.
- WAIT:
  - The counter starts at 0 in the cycle after the last image.
  - out_valid=1 captures out into result[0] and goes to RECV.
  - If the counter reaches TIMEOUT with no out_valid: set err_timeout and go to FIN.
- RECV:
  - Each out_valid cycle stores out into result[n], n incrementing.
  - After O_LEN words, go to FIN.
  - out_valid low before O_LEN words: set err_proto and go to FIN; words already captured are kept.
- Protocol violation: out_valid high during SEND_O/SEND_K/SEND_I sets err_proto, drops all valids to 0 next cycle, and goes to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
  - If out_valid is high in FIN after a complete burst, set err_proto.
- busy is high from the cycle after an accepted start through FIN inclusive.
- Ignored requests:
  - start while busy is ignored, with no effect on the running transfer.
  - wr_en while busy is ignored, so the buffer is unchanged.
- Counters must never wrap past their phase length; the WAIT counter saturates at TIMEOUT.
- rd_data = result[rd_addr] at all times, including while busy (values may be partially updated).

Test Plan:
- Reset then idle: all outputs 0 and busy=0; rd_data=0 for every rd_addr.
- Full transfer:
  - Stimulus: write word k = 0x3F800000+k for k=0..74; start with opt_in=2'b10.
  - Required:
    - Opt=2 for one cycle.
    - Kernel1/2/3 first cycle = 0x3F800000/0x3F800009/0x3F800012 for 9 cycles.
    - Image1 first cycle = 0x3F80001B, Image3 last cycle = 0x3F80004A, 16 cycles.
  - Model NN returns 16 words 0x40000000+n after 5 idle cycles: result[n] matches, done pulses once, no errors.
- Timeout: with TIMEOUT=1000, out_valid is never raised -> err_timeout=1 and done pulses 1000 cycles after the last image; a new start clears err_timeout.
- Short burst: out_valid high 10 cycles then low -> err_proto=1; result[0..9] captured, result[10..15] unchanged; done pulses.
- Early out_valid: out_valid pulsed during the 4th kernel cycle -> all valids 0 next cycle, err_proto=1, done pulses.
- Busy interlock and reset:
  - wr_en to address 0 and a second start during SEND_I -> no buffer change and no restart.
  - rst_n low during RECV -> all outputs 0 asynchronously, no done pulse.
